uart_rx_oversample: RTL and testbench

//  Standalone 8N1 UART receiver on the system clock, the receive-side counterpart of the

---
 rtl/uart_rx_oversample.sv | 207 ++++++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - 16x oversampled 8N1 UART receiver with majority-vote bit recovery
// Define UART_PARITY_EN for 8E1 framing with a parity-error pulse.
module uart_rx_oversample #(
    parameter int CLK_FREQ   = 16_000_000,
    parameter int BAUD       = 1_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx_data,
    output logic [7:0] o_rx_data,
    output logic       o_rx_done,
    output logic       o_rx_active,
    output logic       o_rx_frame_err,
    output logic       o_rx_parity_err
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int TW  = $clog2(DIV) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    state_t      state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        rx_prev_q, rx_prev_d;
    logic [3:0]  s_q, s_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        samp7_q, samp7_d;
    logic        samp8_q, samp8_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        active_q, active_d;
    logic        ferr_q, ferr_d;
`ifdef UART_PARITY_EN
    logic        perr_q, perr_d;
    logic        parity_bad_q, parity_bad_d;
`endif

    logic tick;
    logic rx_s;
    logic maj;
    logic sample_pt;

    always_comb begin
        tick      = (tick_cnt_q == TW'(DIV - 1));
        rx_s      = sync2_q;
        maj       = (samp7_q & samp8_q) | (samp7_q & rx_s) | (samp8_q & rx_s);
        sample_pt = tick && (s_q == 4'd9);

        state_d    = state_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        sync1_d    = i_rx_data;
        sync2_d    = sync1_q;
        rx_prev_d  = rx_s;
        s_d        = s_q;
        bit_idx_d  = bit_idx_q;
        samp7_d    = samp7_q;
        samp8_d    = samp8_q;
        shift_d    = shift_q;
        data_d     = data_q;
        done_d     = 1'b0;
        active_d   = active_q;
        ferr_d     = 1'b0;
`ifdef UART_PARITY_EN
        perr_d       = 1'b0;
        parity_bad_d = parity_bad_q;
`endif

        // s wraps at every bit boundary; votes at 7 and 8 are held for the decision at 9
        if (tick) begin
            s_d = (s_q == 4'd15) ? 4'd0 : s_q + 4'd1;
            if (s_q == 4'd7) samp7_d = rx_s;
            if (s_q == 4'd8) samp8_d = rx_s;
        end

        case (state_q)
            ST_IDLE: begin
                s_d = 4'd0;
                if (rx_prev_q && !rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (sample_pt) begin
                    if (!maj) begin
                        state_d   = ST_DATA;
                        active_d  = 1'b1;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (sample_pt) begin
                    shift_d   = {maj, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (sample_pt) begin
                    parity_bad_d = ^{shift_q, maj};
                    state_d      = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Deciding at mid-stop leaves half a bit to catch a back-to-back start edge
                if (sample_pt) begin
                    active_d = 1'b0;
                    if (maj) begin
                        state_d = ST_IDLE;
`ifdef UART_PARITY_EN
                        if (parity_bad_q) begin
                            perr_d = 1'b1;
                        end else begin
                            data_d = shift_q;
                            done_d = 1'b1;
                        end
`else
                        data_d = shift_q;
                        done_d = 1'b1;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            s_q        <= 4'd0;
            bit_idx_q  <= 3'd0;
            samp7_q    <= 1'b1;
            samp8_q    <= 1'b1;
            shift_q    <= 8'h00;
            data_q     <= 8'h00;
            done_q     <= 1'b0;
            active_q   <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_PARITY_EN
            perr_q       <= 1'b0;
            parity_bad_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            rx_prev_q  <= rx_prev_d;
            s_q        <= s_d;
            bit_idx_q  <= bit_idx_d;
            samp7_q    <= samp7_d;
            samp8_q    <= samp8_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            done_q     <= done_d;
            active_q   <= active_d;
            ferr_q     <= ferr_d;
`ifdef UART_PARITY_EN
            perr_q       <= perr_d;
            parity_bad_q <= parity_bad_d;
`endif
        end
    end

    assign o_rx_data      = data_q;
    assign o_rx_done      = done_q;
    assign o_rx_active    = active_q;
    assign o_rx_frame_err = ferr_q;
`ifdef UART_PARITY_EN
    assign o_rx_parity_err = perr_q;
`else
    assign o_rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb/tb_uart_rx_oversample.sv - scoreboard bench for uart_rx_oversample with randomized frames
module tb_uart_rx_oversample;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] o_rx_data;
    logic       o_rx_done;
    logic       o_rx_active;
    logic       o_rx_frame_err;
    logic       o_rx_parity_err;

    uart_rx_oversample #(
        .CLK_FREQ  (16_000_000),
        .BAUD      (1_000_000),
        .OVERSAMPLE(16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_rx_data      (rx),
        .o_rx_data      (o_rx_data),
        .o_rx_done      (o_rx_done),
        .o_rx_active    (o_rx_active),
        .o_rx_frame_err (o_rx_frame_err),
        .o_rx_parity_err(o_rx_parity_err)
    );

    always #5 clk = ~clk;

    // kind is one-hot {done, frame_err, parity_err}
    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] last_good = 8'h00;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && (o_rx_done || o_rx_frame_err || o_rx_parity_err)) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_pulse", int'({o_rx_done, o_rx_frame_err, o_rx_parity_err}), 0);
            end else begin
                e = exp_q.pop_front();
                chk({o_rx_done, o_rx_frame_err, o_rx_parity_err} == e.kind, "pulse_kind",
                    int'({o_rx_done, o_rx_frame_err, o_rx_parity_err}), int'(e.kind));
                chk(o_rx_data == e.data, "rx_data", int'(o_rx_data), int'(e.data));
                chk(o_rx_active == 1'b0, "active_fall", int'(o_rx_active), 0);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_v, input bit par_flip,
                              input int hold_low);
        exp_t e;
        if (!stop_v) begin
            e.kind = 3'b010;
            e.data = last_good;
        end else if (par_flip) begin
            e.kind = 3'b001;
            e.data = last_good;
        end else begin
            e.kind = 3'b100;
            e.data = b;
            last_good = b;
        end
        exp_q.push_back(e);
        rx = 1'b0;
        wait_clk(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == 4) begin
                wait_clk(8);
                chk(o_rx_active == 1'b1, "active_mid", int'(o_rx_active), 1);
                wait_clk(8);
            end else begin
                wait_clk(16);
            end
        end
`ifdef UART_PARITY_EN
        rx = (^b) ^ par_flip;
        wait_clk(16);
`endif
        rx = stop_v;
        wait_clk(16);
        if (!stop_v) begin
            wait_clk(hold_low);
            rx = 1'b1;
        end
    endtask

    initial begin
        bit         seen;
        int         r;
        logic [7:0] b;

        reset = 1'b1;
        rx = 1'b1;
        wait_clk(3);
        chk(o_rx_data == 8'h00, "reset_data", int'(o_rx_data), 0);
        chk(o_rx_done == 1'b0, "reset_done", int'(o_rx_done), 0);
        chk(o_rx_active == 1'b0, "reset_active", int'(o_rx_active), 0);
        chk(o_rx_frame_err == 1'b0, "reset_ferr", int'(o_rx_frame_err), 0);
        chk(o_rx_parity_err == 1'b0, "reset_perr", int'(o_rx_parity_err), 0);
        reset = 1'b0;
        wait_clk(5);

        send_frame(8'h55, 1'b1, 1'b0, 0);
        send_frame(8'hA3, 1'b1, 1'b0, 0);
        wait_clk(5);

        rx = 1'b0;
        wait_clk(4);
        rx = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (o_rx_active) seen = 1'b1;
            wait_clk(1);
        end
        chk(!seen, "glitch_active", int'(seen), 0);

        send_frame(8'h3C, 1'b0, 1'b0, 40);
        wait_clk(4);
        send_frame(8'h01, 1'b1, 1'b0, 0);
        wait_clk(3);

        rx = 1'b0;
        wait_clk(16);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            wait_clk(16);
        end
        wait_clk(8);
        chk(o_rx_active == 1'b1, "active_before_reset", int'(o_rx_active), 1);
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        last_good = 8'h00;
        chk(o_rx_data == 8'h00, "abort_data", int'(o_rx_data), 0);
        chk(o_rx_active == 1'b0, "abort_active", int'(o_rx_active), 0);
        wait_clk(20);
        send_frame(8'h12, 1'b1, 1'b0, 0);
        wait_clk(2);

`ifdef UART_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 0);
        send_frame(8'h07, 1'b1, 1'b0, 0);
        wait_clk(2);
`endif

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            b = 8'($urandom);
            if (r < 6) begin
                send_frame(b, 1'b1, 1'b0, 0);
                wait_clk($urandom_range(0, 3));
            end else if (r < 8) begin
                send_frame(b, 1'b0, 1'b0, $urandom_range(0, 40));
                wait_clk($urandom_range(4, 8));
            end else begin
`ifdef UART_PARITY_EN
                send_frame(b, 1'b1, 1'b1, 0);
`else
                send_frame(b, 1'b1, 1'b0, 0);
`endif
                wait_clk($urandom_range(0, 3));
            end
        end

        wait_clk(40);
        chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
